// File: rtl/hsiao_64_err_mon.sv
// Error monitor behind a 72/64 Hsiao SEC-DED decoder: counts correctable and
// uncorrectable events, latches the first fatal address, and queues scrub write-backs.
module hsiao_64_err_mon #(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16,
  parameter int CORR_THRESH = 16,
  parameter int DEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic [0:63]       i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_err_corr,
  input  logic              i_err_detec,
  input  logic              i_err_fatal,
  input  logic              i_clr,
  output logic [CNT_W-1:0]  o_corr_cnt,
  output logic [CNT_W-1:0]  o_fatal_cnt,
  output logic [ADDR_W-1:0] o_fatal_addr,
  output logic              o_fatal_vld,
  output logic              o_irq_thresh,
  output logic              o_irq_fatal,
  output logic              o_scrub_ovf,
  output logic              o_scrub_valid,
  output logic [ADDR_W-1:0] o_scrub_addr,
  output logic [0:63]       o_scrub_data,
  input  logic              i_scrub_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(CORR_THRESH);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [PW:0]      PONE   = (PW+1)'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } scrub_req_t;

  // Decoder's corrected-bit flag is implied by detec & ~fatal; carried for completeness.
  logic unused_corr;
  assign unused_corr = i_err_corr;

  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d, fatal_cnt_q, fatal_cnt_d;
  logic [ADDR_W-1:0] fatal_addr_q, fatal_addr_d;
  logic              fatal_vld_q, fatal_vld_d;
  logic              irq_thresh_q, irq_thresh_d;
  logic              irq_fatal_q, irq_fatal_d;
  logic              scrub_ovf_q, scrub_ovf_d;
  scrub_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic sbe, fat, empty, full, push, pop;
  scrub_req_t req;

  assign sbe   = i_valid & i_err_detec & ~i_err_fatal;
  assign fat   = i_valid & i_err_fatal;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop   = ~empty & i_scrub_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = sbe & (~full | pop);
  assign req   = '{addr: i_addr, data: i_data};

  always_comb begin
    // Clear forms the base; a coincident event is applied on top of it.
    corr_cnt_d   = i_clr ? '0 : corr_cnt_q;
    fatal_cnt_d  = i_clr ? '0 : fatal_cnt_q;
    fatal_addr_d = i_clr ? '0 : fatal_addr_q;
    fatal_vld_d  = i_clr ? 1'b0 : fatal_vld_q;
    irq_thresh_d = i_clr ? 1'b0 : irq_thresh_q;
    irq_fatal_d  = i_clr ? 1'b0 : irq_fatal_q;
    scrub_ovf_d  = i_clr ? 1'b0 : scrub_ovf_q;

    if (sbe && corr_cnt_d != '1) corr_cnt_d = corr_cnt_d + ONE;
    if (fat && fatal_cnt_d != '1) fatal_cnt_d = fatal_cnt_d + ONE;
    if (fat && !fatal_vld_d) begin
      fatal_addr_d = i_addr;
      fatal_vld_d  = 1'b1;
    end
    if (corr_cnt_d >= THRESH) irq_thresh_d = 1'b1;
    if (fat) irq_fatal_d = 1'b1;
    if (sbe && !push) scrub_ovf_d = 1'b1;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = req;
      wr_ptr_d = wr_ptr_q + PONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      corr_cnt_q   <= '0;
      fatal_cnt_q  <= '0;
      fatal_addr_q <= '0;
      fatal_vld_q  <= 1'b0;
      irq_thresh_q <= 1'b0;
      irq_fatal_q  <= 1'b0;
      scrub_ovf_q  <= 1'b0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      fatal_cnt_q  <= fatal_cnt_d;
      fatal_addr_q <= fatal_addr_d;
      fatal_vld_q  <= fatal_vld_d;
      irq_thresh_q <= irq_thresh_d;
      irq_fatal_q  <= irq_fatal_d;
      scrub_ovf_q  <= scrub_ovf_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign o_corr_cnt    = corr_cnt_q;
  assign o_fatal_cnt   = fatal_cnt_q;
  assign o_fatal_addr  = fatal_addr_q;
  assign o_fatal_vld   = fatal_vld_q;
  assign o_irq_thresh  = irq_thresh_q;
  assign o_irq_fatal   = irq_fatal_q;
  assign o_scrub_ovf   = scrub_ovf_q;
  assign o_scrub_valid = ~empty;
  assign o_scrub_addr  = mem_q[rd_ptr_q[PW-1:0]].addr;
  assign o_scrub_data  = mem_q[rd_ptr_q[PW-1:0]].data;
endmodule

// File: tb/tb_hsiao_64_err_mon.sv
// Directed bench for hsiao_64_err_mon: a default instance plus a 4-bit-counter
// instance sharing the same stimulus to reach saturation quickly.
module tb_hsiao_64_err_mon;
  logic        clk = 1'b0;
  logic        reset_n, i_valid, i_err_corr, i_err_detec, i_err_fatal, i_clr, i_scrub_ready;
  logic [0:63] i_data;
  logic [31:0] i_addr;

  logic [15:0] corr_cnt, fatal_cnt;
  logic [31:0] fatal_addr, scrub_addr;
  logic        fatal_vld, irq_thresh, irq_fatal, scrub_ovf, scrub_valid;
  logic [0:63] scrub_data;

  logic [3:0]  s_corr_cnt, s_fatal_cnt;
  logic [31:0] s_fatal_addr, s_scrub_addr;
  logic        s_fatal_vld, s_irq_thresh, s_irq_fatal, s_scrub_ovf, s_scrub_valid;
  logic [0:63] s_scrub_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hsiao_64_err_mon dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data), .i_addr(i_addr),
    .i_err_corr(i_err_corr), .i_err_detec(i_err_detec), .i_err_fatal(i_err_fatal), .i_clr(i_clr),
    .o_corr_cnt(corr_cnt), .o_fatal_cnt(fatal_cnt), .o_fatal_addr(fatal_addr), .o_fatal_vld(fatal_vld),
    .o_irq_thresh(irq_thresh), .o_irq_fatal(irq_fatal), .o_scrub_ovf(scrub_ovf),
    .o_scrub_valid(scrub_valid), .o_scrub_addr(scrub_addr), .o_scrub_data(scrub_data),
    .i_scrub_ready(i_scrub_ready));

  hsiao_64_err_mon #(.CNT_W(4), .CORR_THRESH(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_data(i_data), .i_addr(i_addr),
    .i_err_corr(i_err_corr), .i_err_detec(i_err_detec), .i_err_fatal(i_err_fatal), .i_clr(i_clr),
    .o_corr_cnt(s_corr_cnt), .o_fatal_cnt(s_fatal_cnt), .o_fatal_addr(s_fatal_addr), .o_fatal_vld(s_fatal_vld),
    .o_irq_thresh(s_irq_thresh), .o_irq_fatal(s_irq_fatal), .o_scrub_ovf(s_scrub_ovf),
    .o_scrub_valid(s_scrub_valid), .o_scrub_addr(s_scrub_addr), .o_scrub_data(s_scrub_data),
    .i_scrub_ready(i_scrub_ready));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a, ~a};
  endfunction

  // Drive one decoder word (v, detec, fatal, addr) and advance one clock.
  task automatic word(input logic v, input logic d, input logic f, input logic [31:0] a);
    i_valid = v; i_err_detec = d; i_err_fatal = f; i_err_corr = d & ~f;
    i_addr = a; i_data = pat(a);
    tick();
  endtask

  task automatic idle();
    word(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; i_valid = 1'b0; i_err_corr = 1'b0; i_err_detec = 1'b0; i_err_fatal = 1'b0;
    i_clr = 1'b0; i_scrub_ready = 1'b1; i_data = '0; i_addr = '0;
    tick(); tick();
    chk("rst_corr_cnt", corr_cnt, 0);
    chk("rst_fatal_cnt", fatal_cnt, 0);
    chk("rst_scrub_valid", scrub_valid, 0);
    chk("rst_flags", {fatal_vld, irq_thresh, irq_fatal, scrub_ovf}, 0);
    chk("rst_scrub_addr", scrub_addr, 0);
    reset_n = 1'b1;

    // Clean traffic, and flagged words with i_valid low, must be ignored.
    for (int i = 0; i < 10; i++) begin
      word(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i));
      chk("clean_scrub_valid", scrub_valid, 0);
    end
    word(1'b0, 1'b1, 1'b0, 32'h20);
    word(1'b0, 1'b1, 1'b1, 32'h24);
    chk("clean_corr_cnt", corr_cnt, 0);
    chk("clean_fatal_cnt", fatal_cnt, 0);
    chk("clean_flags", {fatal_vld, irq_thresh, irq_fatal, scrub_ovf}, 0);

    // Single sbe with ready high: one-cycle scrub pulse.
    i_valid = 1'b1; i_err_detec = 1'b1; i_err_fatal = 1'b0; i_addr = 32'h100;
    i_data = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    chk("sbe_corr_cnt", corr_cnt, 1);
    chk("sbe_scrub_valid", scrub_valid, 1);
    chk("sbe_scrub_addr", scrub_addr, 32'h100);
    chk("sbe_scrub_data", scrub_data, 64'hA5A5_A5A5_A5A5_A5A5);
    idle();
    chk("sbe_scrub_done", scrub_valid, 0);

    // Threshold: 18 sbe after a clear.
    i_clr = 1'b1; idle(); i_clr = 1'b0;
    chk("clr_corr_cnt", corr_cnt, 0);
    for (int i = 0; i < 18; i++) begin
      word(1'b1, 1'b1, 1'b0, 32'h300 + 32'(i));
      if (i == 14) begin
        chk("thr_cnt15", corr_cnt, 15);
        chk("thr_irq_low", irq_thresh, 0);
      end
      if (i == 15) begin
        chk("thr_cnt16", corr_cnt, 16);
        chk("thr_irq_rise", irq_thresh, 1);
      end
    end
    chk("thr_cnt18", corr_cnt, 18);
    chk("thr_irq_hold", irq_thresh, 1);
    chk("sat_cnt15", s_corr_cnt, 15);
    chk("sat_irq", s_irq_thresh, 1);
    // Clear coincident with an sbe while the 4-bit counter is saturated.
    i_clr = 1'b1; word(1'b1, 1'b1, 1'b0, 32'h400); i_clr = 1'b0;
    chk("clrsbe_corr_cnt", corr_cnt, 1);
    chk("clrsbe_irq", irq_thresh, 0);
    chk("clrsbe_sat_cnt", s_corr_cnt, 1);
    chk("clrsbe_sat_irq", s_irq_thresh, 0);
    idle(); idle();
    chk("thr_drained", scrub_valid, 0);

    // Fatal capture: first address kept, nothing queued.
    i_clr = 1'b1; idle(); i_clr = 1'b0;
    word(1'b1, 1'b1, 1'b1, 32'h40);
    chk("fat1_cnt", fatal_cnt, 1);
    chk("fat1_addr", fatal_addr, 32'h40);
    chk("fat1_vld_irq", {fatal_vld, irq_fatal}, 2'b11);
    word(1'b1, 1'b1, 1'b1, 32'h80);
    chk("fat2_cnt", fatal_cnt, 2);
    chk("fat2_addr", fatal_addr, 32'h40);
    chk("fat2_irq", irq_fatal, 1);
    chk("fat_no_scrub", scrub_valid, 0);
    chk("fat_corr_cnt", corr_cnt, 0);

    // Overflow: ready low, DEPTH+1 sbe.
    i_clr = 1'b1; idle(); i_clr = 1'b0;
    chk("clr_fatal", {fatal_vld, irq_fatal, fatal_addr, fatal_cnt}, 0);
    i_scrub_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      word(1'b1, 1'b1, 1'b0, 32'h200 + 32'(i));
      if (i == 3) chk("ovf_not_yet", scrub_ovf, 0);
    end
    chk("ovf_set", scrub_ovf, 1);
    chk("ovf_corr_cnt", corr_cnt, 5);
    chk("ovf_head_addr", scrub_addr, 32'h200);
    idle();
    chk("ovf_head_stable", scrub_addr, 32'h200);
    chk("ovf_head_data", scrub_data, pat(32'h200));
    i_clr = 1'b1; idle(); i_clr = 1'b0;
    chk("clr_ovf", {scrub_ovf, corr_cnt}, 0);
    chk("clr_keeps_fifo", {scrub_valid, scrub_addr}, {1'b1, 32'h200});
    // Full + push + pop: no drop.
    i_scrub_ready = 1'b1;
    word(1'b1, 1'b1, 1'b0, 32'h205);
    chk("fpp_no_ovf", scrub_ovf, 0);
    chk("fpp_head", scrub_addr, 32'h201);
    idle(); chk("drain_202", {scrub_valid, scrub_addr}, {1'b1, 32'h202});
    idle(); chk("drain_203", {scrub_valid, scrub_addr}, {1'b1, 32'h203});
    idle(); chk("drain_205", {scrub_valid, scrub_addr}, {1'b1, 32'h205});
    chk("drain_205_data", scrub_data, pat(32'h205));
    idle(); chk("drain_empty", scrub_valid, 0);

    // Reset mid-drain empties the FIFO.
    i_scrub_ready = 1'b0;
    for (int i = 0; i < 3; i++) word(1'b1, 1'b1, 1'b0, 32'h500 + 32'(i));
    i_scrub_ready = 1'b1;
    idle();
    chk("mid_head", {scrub_valid, scrub_addr}, {1'b1, 32'h501});
    reset_n = 1'b0; idle(); reset_n = 1'b1;
    chk("mid_rst_valid", scrub_valid, 0);
    chk("mid_rst_cnt", corr_cnt, 0);
    idle();
    chk("mid_rst_stays", scrub_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
